multicore_loader_ctrl: RTL and testbench

MULTICORE_LOADER_CTRL -- requirements
Module: multicore_loader_ctrl

---
 rtl/multicore_loader_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_multicore_loader_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_loader_ctrl.sv
// Multicore loader controller: streams words into per-core IRAMs or the
// shared DRAM, runs the cores for a fixed number of cycles, and reads a
// DRAM address range back out as a handshaked stream.
module multicore_loader_ctrl #(
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_op,
  // One bit wider than the core index so out-of-range cores can be requested and rejected
  input  logic [$clog2(NUM_CORES+1)-1:0]     cmd_core,
  input  logic [ADDR_W-1:0]                  cmd_addr_start,
  input  logic [ADDR_W-1:0]                  cmd_addr_end,
  input  logic [31:0]                        cmd_run_cycles,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DATA_W-1:0]                  s_data,
  input  logic                               s_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [DATA_W-1:0]                  m_data,
  output logic                               m_last,
  output logic [ADDR_W-1:0]                  addr_ext,
  output logic [DATA_W-1:0]                  Data_in_ins,
  output logic [DATA_W-1:0]                  Data_in_dram,
  output logic [NUM_CORES-1:0]               iram_write_ext,
  output logic                               dram_write_ext,
  output logic                               read_en_ext,
  input  logic [DATA_W-1:0]                  dram_in,
  output logic                               start,
  output logic                               start_2,
  output logic                               start_3,
  output logic                               start_4,
  output logic                               busy,
  output logic                               err
);

  localparam int CORE_W = $clog2(NUM_CORES+1);
  localparam logic [1:0] OP_LOAD_IRAM = 2'd0;
  localparam logic [1:0] OP_LOAD_DRAM = 2'd1;
  localparam logic [1:0] OP_RUN       = 2'd2;
  localparam logic [1:0] OP_READ      = 2'd3;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [CORE_W-1:0] CORE_LIM  = CORE_W'(NUM_CORES);
  // Remaining RD_WAIT cycles after RD_ISSUE, minus one
  localparam logic [31:0] WAIT_INIT = (RD_LAT >= 2) ? 32'(RD_LAT - 2) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CORE_W-1:0]   r_core;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_end;
  logic [31:0]         r_run_cnt;
  logic [31:0]         r_lat_cnt;
  logic [DATA_W-1:0]   r_rd_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_stb_i;
  logic                r_stb_d;
  logic                r_err;

  logic w_cmd_fire;
  logic w_s_fire;
  logic w_bad_core;
  logic w_bad_range;
  logic w_rd_last;
  logic w_load_end;

  assign w_cmd_fire  = cmd_valid && (r_state == S_IDLE);
  assign w_s_fire    = s_valid && ((r_state == S_LOAD_I) || (r_state == S_LOAD_D));
  assign w_bad_core  = (cmd_core >= CORE_LIM);
  assign w_bad_range = (cmd_addr_start >= cmd_addr_end);
  assign w_rd_last   = (r_addr == (r_end - ADDR_W'(1)));
  assign w_load_end  = w_s_fire && (s_last || (r_addr == ADDR_MAX));

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode plus the outputs that depend only on the current state
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    s_ready      = 1'b0;
    start        = 1'b0;
    start_2      = 1'b0;
    start_3      = 1'b0;
    start_4      = 1'b0;
    busy         = 1'b1;
    m_valid      = 1'b0;
    read_en_ext  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_cmd_fire) begin
          case (cmd_op)
            OP_LOAD_IRAM: if (!w_bad_core)             w_next_state = S_LOAD_I;
            OP_LOAD_DRAM:                              w_next_state = S_LOAD_D;
            OP_RUN:       if (cmd_run_cycles != 32'd0) w_next_state = S_RUN;
            default:      if (!w_bad_range)            w_next_state = S_RD_ISSUE;
          endcase
        end
      end
      S_LOAD_I: begin
        s_ready = 1'b1;
        start_2 = 1'b1;
        if (w_load_end) w_next_state = S_IDLE;
      end
      S_LOAD_D: begin
        s_ready = 1'b1;
        start_3 = 1'b1;
        if (w_load_end) w_next_state = S_IDLE;
      end
      S_RUN: begin
        start = 1'b1;
        if (r_run_cnt <= 32'd1) w_next_state = S_IDLE;
      end
      S_RD_ISSUE: begin
        start_4     = 1'b1;
        read_en_ext = 1'b1;
        w_next_state = (RD_LAT == 1) ? S_RD_OUT : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        start_4     = 1'b1;
        read_en_ext = 1'b1;
        if (r_lat_cnt == 32'd0) w_next_state = S_RD_OUT;
      end
      S_RD_OUT: begin
        start_4 = 1'b1;
        m_valid = 1'b1;
        if (m_ready) w_next_state = w_rd_last ? S_IDLE : S_RD_ISSUE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command latching, load write pipeline, run countdown and read capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_core    <= '0;
      r_addr    <= '0;
      r_end     <= '0;
      r_run_cnt <= '0;
      r_lat_cnt <= '0;
      r_rd_data <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_stb_i   <= 1'b0;
      r_stb_d   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_stb_i <= 1'b0;
      r_stb_d <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_core    <= cmd_core;
            r_addr    <= cmd_addr_start;
            r_end     <= cmd_addr_end;
            r_run_cnt <= cmd_run_cycles;
            if (((cmd_op == OP_LOAD_IRAM) && w_bad_core) ||
                ((cmd_op == OP_READ) && w_bad_range))
              r_err <= 1'b1;
          end
        end
        S_LOAD_I, S_LOAD_D: begin
          if (w_s_fire) begin
            r_wr_addr <= r_addr;
            r_wr_data <= s_data;
            r_stb_i   <= (r_state == S_LOAD_I);
            r_stb_d   <= (r_state == S_LOAD_D);
            if (r_addr != ADDR_MAX) r_addr <= r_addr + ADDR_W'(1);
            else if (!s_last)       r_err  <= 1'b1;
          end
        end
        S_RUN: r_run_cnt <= r_run_cnt - 32'd1;
        S_RD_ISSUE: begin
          r_lat_cnt <= WAIT_INIT;
          if (RD_LAT == 1) r_rd_data <= dram_in;
        end
        S_RD_WAIT: begin
          if (r_lat_cnt == 32'd0) r_rd_data <= dram_in;
          else                    r_lat_cnt <= r_lat_cnt - 32'd1;
        end
        S_RD_OUT: begin
          if (m_ready && !w_rd_last) r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs: pending write strobe owns the address bus, else the read pointer
  always_comb begin
    iram_write_ext = '0;
    dram_write_ext = r_stb_d;
    Data_in_ins    = '0;
    Data_in_dram   = '0;
    addr_ext       = '0;
    m_data         = '0;
    m_last         = 1'b0;
    err            = r_err;
    if (r_stb_i) begin
      iram_write_ext = NUM_CORES'(1) << r_core;
      Data_in_ins    = r_wr_data;
    end
    if (r_stb_d) Data_in_dram = r_wr_data;
    if (r_stb_i || r_stb_d) addr_ext = r_wr_addr;
    else if (start_4)       addr_ext = r_addr;
    if (r_state == S_RD_OUT) begin
      m_data = r_rd_data;
      m_last = w_rd_last;
    end
  end

endmodule

// File: tb/tb_multicore_loader_ctrl.sv
// Directed testbench for multicore_loader_ctrl: loads, run, readback,
// error cases and reset abort, with hand-computed expectations.
module tb_multicore_loader_ctrl;

  localparam int NUM_CORES = 8;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 2;
  localparam int CORE_W    = $clog2(NUM_CORES+1);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [1:0]           cmd_op = '0;
  logic [CORE_W-1:0]    cmd_core = '0;
  logic [ADDR_W-1:0]    cmd_addr_start = '0;
  logic [ADDR_W-1:0]    cmd_addr_end = '0;
  logic [31:0]          cmd_run_cycles = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_data = '0;
  logic                 s_last = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [DATA_W-1:0]    m_data;
  logic                 m_last;
  logic [ADDR_W-1:0]    addr_ext;
  logic [DATA_W-1:0]    Data_in_ins;
  logic [DATA_W-1:0]    Data_in_dram;
  logic [NUM_CORES-1:0] iram_write_ext;
  logic                 dram_write_ext;
  logic                 read_en_ext;
  logic [DATA_W-1:0]    dram_in;
  logic                 start;
  logic                 start_2;
  logic                 start_3;
  logic                 start_4;
  logic                 busy;
  logic                 err;

  int nTests = 0;
  int nFail  = 0;

  // DRAM model: read data is a fixed function of the presented address
  assign dram_in = 16'h5A00 ^ {7'b0, addr_ext};

  always #5 clock = ~clock;

  multicore_loader_ctrl #(
    .NUM_CORES(NUM_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_core(cmd_core), .cmd_addr_start(cmd_addr_start),
    .cmd_addr_end(cmd_addr_end), .cmd_run_cycles(cmd_run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .addr_ext(addr_ext), .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
    .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
    .read_en_ext(read_en_ext), .dram_in(dram_in),
    .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nTests++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one command in IDLE and let it be accepted on the next edge
  task automatic applyStimulus(input logic [1:0] op, input logic [CORE_W-1:0] core,
                               input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                               input logic [31:0] cyc);
    checkOutput("cmd_ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_op = op; cmd_core = core; cmd_addr_start = a0; cmd_addr_end = a1;
    cmd_run_cycles = cyc; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    checkOutput({tag, "_quiet"}, 64'({s_ready, m_valid, m_last, dram_write_ext,
                 read_en_ext, start, start_2, start_3, start_4, busy, err}), 64'(0));
    checkOutput({tag, "_iram"}, 64'(iram_write_ext), 64'(0));
    checkOutput({tag, "_buses"}, 64'({addr_ext, Data_in_ins, Data_in_dram, m_data}), 64'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] expData [3];
    int cnt;
    expData[0] = 16'h5A64;
    expData[1] = 16'h5A65;
    expData[2] = 16'h5A66;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    checkIdleOutputs("reset");
    reset = 1'b0;
    tick();

    // LOAD_IRAM core 3 from address 1: words 10, 20, 30
    applyStimulus(2'd0, 4'd3, 9'd1, 9'd0, 32'd0);
    checkOutput("li_start_2", 64'({start, start_2, start_3, start_4}), 64'(4'b0100));
    checkOutput("li_s_ready", 64'(s_ready), 64'(1));
    s_valid = 1'b1; s_data = 16'd10; s_last = 1'b0;
    tick();
    checkOutput("li_w0_strobe", 64'(iram_write_ext), 64'(8'b0000_1000));
    checkOutput("li_w0_addr", 64'(addr_ext), 64'(1));
    checkOutput("li_w0_data", 64'(Data_in_ins), 64'(10));
    checkOutput("li_w0_dram", 64'(dram_write_ext), 64'(0));
    checkOutput("li_w0_start_2", 64'(start_2), 64'(1));
    s_data = 16'd20;
    tick();
    checkOutput("li_w1_strobe", 64'(iram_write_ext), 64'(8'b0000_1000));
    checkOutput("li_w1_addr", 64'(addr_ext), 64'(2));
    checkOutput("li_w1_data", 64'(Data_in_ins), 64'(20));
    s_data = 16'd30; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    checkOutput("li_w2_strobe", 64'(iram_write_ext), 64'(8'b0000_1000));
    checkOutput("li_w2_addr", 64'(addr_ext), 64'(3));
    checkOutput("li_w2_data", 64'(Data_in_ins), 64'(30));
    checkOutput("li_done_idle", 64'({cmd_ready, start_2, s_ready}), 64'(3'b100));
    tick();
    checkOutput("li_after_strobe", 64'(iram_write_ext), 64'(0));

    // LOAD_DRAM from 510 with no s_last: stops at the top address with err
    applyStimulus(2'd1, 4'd0, 9'd510, 9'd0, 32'd0);
    checkOutput("ld_start_3", 64'({start, start_2, start_3, start_4}), 64'(4'b0010));
    s_valid = 1'b1; s_data = 16'h0111; s_last = 1'b0;
    tick();
    checkOutput("ld_w0", 64'({dram_write_ext, addr_ext, Data_in_dram}),
                64'({1'b1, 9'd510, 16'h0111}));
    checkOutput("ld_w0_iram", 64'(iram_write_ext), 64'(0));
    checkOutput("ld_w0_err", 64'(err), 64'(0));
    s_data = 16'h0222;
    tick();
    checkOutput("ld_w1", 64'({dram_write_ext, addr_ext, Data_in_dram}),
                64'({1'b1, 9'd511, 16'h0222}));
    checkOutput("ld_overflow_err", 64'(err), 64'(1));
    checkOutput("ld_overflow_idle", 64'({s_ready, start_3, cmd_ready}), 64'(3'b001));
    s_data = 16'h0333;
    tick();
    checkOutput("ld_third_not_taken", 64'({dram_write_ext, err, s_ready}), 64'(0));
    s_valid = 1'b0;

    // RUN 5 cycles
    applyStimulus(2'd2, 4'd0, 9'd0, 9'd0, 32'd5);
    cnt = 0;
    while (start === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    checkOutput("run5_length", 64'(cnt), 64'(5));
    checkOutput("run5_back_idle", 64'({cmd_ready, busy}), 64'(2'b10));

    // RUN 0 cycles
    applyStimulus(2'd2, 4'd0, 9'd0, 9'd0, 32'd0);
    checkOutput("run0_no_start", 64'({start, busy}), 64'(0));
    checkOutput("run0_ready", 64'(cmd_ready), 64'(1));
    tick();
    checkOutput("run0_no_start_later", 64'(start), 64'(0));

    // READ 100..103 with a stall on every beat
    applyStimulus(2'd3, 4'd0, 9'd100, 9'd103, 32'd0);
    checkOutput("rd_start_4", 64'({start, start_2, start_3, start_4}), 64'(4'b0001));
    for (int b = 0; b < 3; b++) begin
      cnt = 0;
      while (read_en_ext === 1'b1 && cnt < 10) begin
        checkOutput($sformatf("rd_b%0d_addr", b), 64'(addr_ext), 64'(100 + b));
        cnt++;
        tick();
      end
      checkOutput($sformatf("rd_b%0d_read_len", b), 64'(cnt), 64'(2));
      checkOutput($sformatf("rd_b%0d_beat", b), 64'({m_valid, m_last, m_data}),
                  64'({1'b1, (b == 2), expData[b]}));
      m_ready = 1'b0;
      tick();
      checkOutput($sformatf("rd_b%0d_stall", b), 64'({m_valid, m_last, m_data}),
                  64'({1'b1, (b == 2), expData[b]}));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    checkOutput("rd_done_idle", 64'({cmd_ready, m_valid, start_4}), 64'(3'b100));

    // Empty READ range: err, no beat
    applyStimulus(2'd3, 4'd0, 9'd50, 9'd50, 32'd0);
    checkOutput("rd_empty_err", 64'({err, m_valid, start_4, cmd_ready}), 64'(4'b1001));
    tick();
    checkOutput("rd_empty_err_pulse", 64'({err, m_valid}), 64'(0));

    // LOAD_IRAM to nonexistent core 8: err, no strobe, stays IDLE
    applyStimulus(2'd0, 4'd8, 9'd5, 9'd0, 32'd0);
    checkOutput("bad_core_err", 64'({err, start_2, s_ready, cmd_ready}), 64'(4'b1001));
    checkOutput("bad_core_iram", 64'(iram_write_ext), 64'(0));
    tick();
    checkOutput("bad_core_err_pulse", 64'({err, iram_write_ext}), 64'(0));

    // Reset while a readback beat is waiting
    applyStimulus(2'd3, 4'd0, 9'd200, 9'd202, 32'd0);
    cnt = 0;
    while (m_valid !== 1'b1 && cnt < 10) begin
      cnt++;
      tick();
    end
    checkOutput("rst_rd_beat_up", 64'(m_valid), 64'(1));
    reset = 1'b1;
    tick();
    checkIdleOutputs("rst_mid_read");
    reset = 1'b0;
    m_ready = 1'b1;
    tick(); tick();
    checkOutput("rst_no_more_beats", 64'({m_valid, err, read_en_ext}), 64'(0));
    m_ready = 1'b0;

    // Reset on the same edge a load word would be accepted: no strobe follows
    applyStimulus(2'd0, 4'd0, 9'd7, 9'd0, 32'd0);
    s_valid = 1'b1; s_data = 16'hBEEF; s_last = 1'b0;
    reset = 1'b1;
    tick();
    s_valid = 1'b0;
    checkIdleOutputs("rst_mid_load");
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
